traffic_controller: RTL and testbench
=====================================

TRAFFIC_CONTROLLER -- requirements
Module: traffic_controller

Interface
REQ-001 Parameter GREEN_CYCLES, default 20, SHALL set the minimum number of cycles per green phase.
REQ-002 Parameter YELLOW_CYCLES, default 4, SHALL set the exact number of cycles per yellow phase.
REQ-003 Parameter ALLRED_CYCLES, default 2, SHALL set the exact number of cycles per all-red clearance phase.
REQ-004 Parameter WALK_CYCLES, default 10, SHALL set the exact number of cycles per pedestrian walk phase.
REQ-005 Parameter CNT_W, default 8, SHALL set the phase timer width; every *_CYCLES value SHALL be in 1..2^CNT_W-1, enforced by an elaboration-time check.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 side_req  input  1  level; vehicle present on the side road.
REQ-009 ped_req  input  1  pedestrian button; sampled every cycle.
REQ-010 main_light  output  3  one-hot {R,Y,G}: 100 red, 010 yellow, 001 green.
REQ-011 side_light  output  3  same encoding as main_light.
REQ-012 walk  output  1  high only in WALK.
REQ-013 phase  output  3  current FSM state encoding.

Function
REQ-014 FSM states SHALL be MAIN_GREEN, MAIN_YELLOW, ALL_RED_A, SIDE_GREEN, SIDE_YELLOW, ALL_RED_B, WALK.
REQ-015 The phase timer SHALL be 0 on the first cycle of every state and increment by 1 each cycle in that state; it SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-016 A state of duration N SHALL leave when timer == N-1, so it occupies exactly N cycles.
REQ-017 MAIN_GREEN -> MAIN_YELLOW SHALL occur only when timer >= GREEN_CYCLES-1 and (side_req or ped_pend); otherwise MAIN_GREEN holds indefinitely.
REQ-018 MAIN_YELLOW -> ALL_RED_A after YELLOW_CYCLES.
REQ-019 ALL_RED_A after ALLRED_CYCLES -> SIDE_GREEN if side_req, else WALK.
REQ-020 SIDE_GREEN -> SIDE_YELLOW when timer >= GREEN_CYCLES-1 and side_req is low, or timer == 2*GREEN_CYCLES-1 (hard cap), whichever is first.
REQ-021 SIDE_YELLOW -> ALL_RED_B after YELLOW_CYCLES.
REQ-022 ALL_RED_B after ALLRED_CYCLES -> WALK if ped_pend, else MAIN_GREEN.
REQ-023 WALK -> MAIN_GREEN after WALK_CYCLES.
REQ-024 ped_pend SHALL set on any cycle with ped_req high outside WALK; it SHALL clear on the cycle WALK is entered; ped_req high during WALK SHALL be ignored.
REQ-025 ped_req and the WALK-entry transition in the same cycle: clear wins, and the request is dropped.
REQ-026 Lights SHALL be Moore outputs decoded from state only: main green/yellow in MAIN_*, side green/yellow in SIDE_*, both red in ALL_RED_*, WALK, and reset.
REQ-027 main_light and side_light SHALL never both be non-red in the same cycle.

Reset
REQ-028 While rst_n is low: state = ALL_RED_B, timer = 0, ped_pend = 0, main_light = side_light = 100, walk = 0; this takes effect immediately, without waiting for clk.
REQ-029 Reset assertion mid-phase SHALL abort that phase with no yellow step.
REQ-030 After rst_n rises, ALL_RED_B SHALL run ALLRED_CYCLES, then enter MAIN_GREEN.

Structure
REQ-031 Shared package tl_pkg SHALL hold the state enum, the light encodings LT_RED/LT_YEL/LT_GRN, and the phase encoding.
REQ-032 The timer SHALL be a sub-module tl_phase_timer (CNT_W param; clear, saturating count), instantiated once.

Verification (GREEN=4, YELLOW=2, ALLRED=1, WALK=3)
REQ-033 Release reset, inputs low -> 1 cycle both red, then main 001 held 50 cycles, side 100 throughout.
REQ-034 side_req=1 from cycle 0 of MAIN_GREEN -> main 001 x4, 010 x2, both red x1, side 001 x4 once side_req drops at SIDE_GREEN timer 1, then side 010 x2, red x1, main 001.
REQ-035 side_req held high -> SIDE_GREEN lasts exactly 8 cycles (cap).
REQ-036 ped_req one-cycle pulse in MAIN_GREEN, side_req=0 -> MY x2, AR_A x1, walk=1 x3, then MAIN_GREEN; ped_pend=0 afterwards.
REQ-037 ped_req pulse during WALK -> no second WALK; ped_req in SIDE_GREEN -> WALK follows ALL_RED_B.
REQ-038 rst_n low mid-SIDE_GREEN -> both lights 100 in the same cycle, with no clk edge needed; every cycle is checked against REQ-027 by assertion.

Source files
------------

// File: rtl/tl_pkg.sv
// Shared types for the traffic light controller:
// state enum, light encodings and phase encoding.
package tl_pkg;

  localparam int PHASE_W = 3;

  typedef enum logic [PHASE_W-1:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED_A   = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALL_RED_B   = 3'd5,
    WALK        = 3'd6
  } state_t;

  // One-hot {R,Y,G}
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  function automatic logic [PHASE_W-1:0] phase_enc(
    input state_t s
  );
    return s;
  endfunction

endpackage

// File: rtl/tl_phase_timer.sv
// Phase timer: cleared on state change, otherwise
// counts up and saturates at all-ones.
module tl_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_controller.sv
// Two-road intersection controller with pedestrian
// walk phase, minimum/capped greens and all-red clearance.
module traffic_controller
  import tl_pkg::*;
#(
  parameter int GREEN_CYCLES  = 20,
  parameter int YELLOW_CYCLES = 4,
  parameter int ALLRED_CYCLES = 2,
  parameter int WALK_CYCLES   = 10,
  parameter int CNT_W         = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         side_req,
  input  logic         ped_req,
  output logic [2:0]   main_light,
  output logic [2:0]   side_light,
  output logic         walk,
  output logic [2:0]   phase
);

  localparam int MAXV = (1 << CNT_W) - 1;

  if (GREEN_CYCLES  < 1 || GREEN_CYCLES  > MAXV ||
      YELLOW_CYCLES < 1 || YELLOW_CYCLES > MAXV ||
      ALLRED_CYCLES < 1 || ALLRED_CYCLES > MAXV ||
      WALK_CYCLES   < 1 || WALK_CYCLES   > MAXV)
  begin : g_bad_cycles
    $error("traffic_controller: *_CYCLES out of range");
  end

  // Side-green cap clamps to the saturated timer value
  localparam int CAP_I =
    (2 * GREEN_CYCLES - 1 > MAXV) ? MAXV
                                  : 2 * GREEN_CYCLES - 1;

  localparam logic [CNT_W-1:0] G_LAST =
    CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LAST =
    CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LAST =
    CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_LAST =
    CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] CAP =
    CNT_W'(CAP_I);

  state_t           r_state;
  state_t           w_next;
  logic             r_ped_pend;
  logic             w_ped_pend_nxt;
  logic             w_enter_walk;
  logic             w_clr;
  logic [CNT_W-1:0] w_timer;

  tl_phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (w_clr),
    .o_cnt (w_timer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ALL_RED_B;
      r_ped_pend <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_ped_pend <= w_ped_pend_nxt;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      MAIN_GREEN:
        if (w_timer >= G_LAST &&
            (side_req || r_ped_pend))
          w_next = MAIN_YELLOW;
      MAIN_YELLOW:
        if (w_timer == Y_LAST)
          w_next = ALL_RED_A;
      ALL_RED_A:
        if (w_timer == AR_LAST)
          w_next = side_req ? SIDE_GREEN : WALK;
      SIDE_GREEN:
        if ((w_timer >= G_LAST && !side_req) ||
            w_timer == CAP)
          w_next = SIDE_YELLOW;
      SIDE_YELLOW:
        if (w_timer == Y_LAST)
          w_next = ALL_RED_B;
      ALL_RED_B:
        if (w_timer == AR_LAST)
          w_next = r_ped_pend ? WALK : MAIN_GREEN;
      WALK:
        if (w_timer == W_LAST)
          w_next = MAIN_GREEN;
      default:
        w_next = ALL_RED_B;
    endcase
  end

  assign w_clr = (w_next != r_state);

  // Entering WALK consumes the request, even one arriving now
  assign w_enter_walk =
    (w_next == WALK) && (r_state != WALK);

  always_comb begin
    w_ped_pend_nxt = r_ped_pend;
    if (w_enter_walk)
      w_ped_pend_nxt = 1'b0;
    else if (ped_req && r_state != WALK)
      w_ped_pend_nxt = 1'b1;
  end

  always_comb begin
    main_light = LT_RED;
    side_light = LT_RED;
    walk       = 1'b0;
    unique case (1'b1)
      (r_state == MAIN_GREEN):  main_light = LT_GRN;
      (r_state == MAIN_YELLOW): main_light = LT_YEL;
      (r_state == SIDE_GREEN):  side_light = LT_GRN;
      (r_state == SIDE_YELLOW): side_light = LT_YEL;
      (r_state == WALK):        walk       = 1'b1;
      default: ;
    endcase
  end

  assign phase = phase_enc(r_state);

endmodule

// File: tb/tb_traffic_controller.sv
// Bench for traffic_controller: directed phase sequences
// plus random stimulus against a behavioural model.
module tb_traffic_controller;
  import tl_pkg::*;

  localparam int G  = 4;
  localparam int Y  = 2;
  localparam int AR = 1;
  localparam int W  = 3;

  localparam int P_MG  = 0;
  localparam int P_MY  = 1;
  localparam int P_ARA = 2;
  localparam int P_SG  = 3;
  localparam int P_SY  = 4;
  localparam int P_ARB = 5;
  localparam int P_WK  = 6;

  logic       clk;
  logic       rst_n;
  logic       side_req;
  logic       ped_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       walk;
  logic [2:0] phase;

  int n_tests = 0;
  int n_fail  = 0;

  int m_ph;
  int m_el;
  bit m_pend;

  traffic_controller #(
    .GREEN_CYCLES  (G),
    .YELLOW_CYCLES (Y),
    .ALLRED_CYCLES (AR),
    .WALK_CYCLES   (W),
    .CNT_W         (8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .side_req   (side_req),
    .ped_req    (ped_req),
    .main_light (main_light),
    .side_light (side_light),
    .walk       (walk),
    .phase      (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // Both roads never show non-red together
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_tests++;
      assert (!(main_light !== LT_RED &&
                side_light !== LT_RED)) else begin
        n_fail++;
        $error("FAIL conflict observed=%0h/%0h expected=red",
               main_light, side_light);
      end
    end
  end

  function automatic logic [2:0] m_main(input int ph);
    if (ph == P_MG) return LT_GRN;
    if (ph == P_MY) return LT_YEL;
    return LT_RED;
  endfunction

  function automatic logic [2:0] m_side(input int ph);
    if (ph == P_SG) return LT_GRN;
    if (ph == P_SY) return LT_YEL;
    return LT_RED;
  endfunction

  function automatic logic [2:0] m_phase(input int ph);
    case (ph)
      P_MG:    return MAIN_GREEN;
      P_MY:    return MAIN_YELLOW;
      P_ARA:   return ALL_RED_A;
      P_SG:    return SIDE_GREEN;
      P_SY:    return SIDE_YELLOW;
      P_WK:    return WALK;
      default: return ALL_RED_B;
    endcase
  endfunction

  task automatic model_reset();
    m_ph   = P_ARB;
    m_el   = 0;
    m_pend = 1'b0;
  endtask

  // Advance the model by one clock given this cycle's inputs;
  // `done` is the number of cycles spent in the phase so far.
  task automatic model_step(input bit s, input bit p);
    int nxt;
    int done;
    done = m_el + 1;
    nxt  = m_ph;
    case (m_ph)
      P_MG:  if (done >= G && (s || m_pend)) nxt = P_MY;
      P_MY:  if (done == Y)  nxt = P_ARA;
      P_ARA: if (done == AR) nxt = s ? P_SG : P_WK;
      P_SG:  if ((done >= G && !s) || done == 2 * G)
               nxt = P_SY;
      P_SY:  if (done == Y)  nxt = P_ARB;
      P_ARB: if (done == AR) nxt = m_pend ? P_WK : P_MG;
      P_WK:  if (done == W)  nxt = P_MG;
      default: nxt = P_ARB;
    endcase
    if (nxt == P_WK && m_ph != P_WK) m_pend = 1'b0;
    else if (p && m_ph != P_WK)      m_pend = 1'b1;
    m_el = (nxt != m_ph) ? 0 : m_el + 1;
    m_ph = nxt;
  endtask

  // Called at a falling edge: check, then clock once
  task automatic step(input bit s, input bit p);
    side_req = s;
    ped_req  = p;
    chk("model_main",  main_light, m_main(m_ph));
    chk("model_side",  side_light, m_side(m_ph));
    chk("model_walk",  walk, (m_ph == P_WK));
    chk("model_phase", phase, m_phase(m_ph));
    @(posedge clk);
    model_step(s, p);
    @(negedge clk);
  endtask

  task automatic seg(input string tag,
                     input bit s, input bit p,
                     input logic [2:0] em,
                     input logic [2:0] es,
                     input bit ew, input int n);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_main"}, main_light, em);
      chk({tag, "_side"}, side_light, es);
      chk({tag, "_walk"}, walk, ew);
      step(s, p);
    end
  endtask

  // Drop reset between edges; outputs must react at once
  task automatic do_reset();
    rst_n    = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    #2;
    chk("rst_main",  main_light, LT_RED);
    chk("rst_side",  side_light, LT_RED);
    chk("rst_walk",  walk, 1'b0);
    chk("rst_phase", phase, ALL_RED_B);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt;
    bit rs;
    rst_n    = 1'b0;
    side_req = 1'b0;
    ped_req  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);

    // Idle: one red cycle, then main green held
    do_reset();
    seg("idle_arb", 0, 0, LT_RED, LT_RED, 0, 1);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (main_light === LT_GRN &&
          side_light === LT_RED) cnt++;
      step(0, 0);
    end
    chk("idle_green_hold", cnt, 50);

    // Side request dropped at SIDE_GREEN timer 1
    do_reset();
    seg("s1_arb", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("s1_mg",  1, 0, LT_GRN, LT_RED, 0, 4);
    seg("s1_my",  1, 0, LT_YEL, LT_RED, 0, 2);
    seg("s1_ara", 1, 0, LT_RED, LT_RED, 0, 1);
    seg("s1_sg0", 1, 0, LT_RED, LT_GRN, 0, 1);
    seg("s1_sg",  0, 0, LT_RED, LT_GRN, 0, 3);
    seg("s1_sy",  0, 0, LT_RED, LT_YEL, 0, 2);
    seg("s1_arb", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("s1_mg2", 0, 0, LT_GRN, LT_RED, 0, 2);

    // Side request held: side green capped
    do_reset();
    seg("cap_arb", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("cap_mg",  1, 0, LT_GRN, LT_RED, 0, 4);
    seg("cap_my",  1, 0, LT_YEL, LT_RED, 0, 2);
    seg("cap_ara", 1, 0, LT_RED, LT_RED, 0, 1);
    cnt = 0;
    while (side_light === LT_GRN && cnt < 20) begin
      cnt++;
      step(1, 0);
    end
    chk("cap_sg_len", cnt, 2 * G);
    seg("cap_sy",  0, 0, LT_RED, LT_YEL, 0, 2);
    seg("cap_arb", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("cap_mg2", 0, 0, LT_GRN, LT_RED, 0, 2);

    // Ped pulse in MAIN_GREEN; request on WALK entry
    // and during WALK both dropped
    do_reset();
    seg("p_arb",  0, 0, LT_RED, LT_RED, 0, 1);
    seg("p_mg0",  0, 1, LT_GRN, LT_RED, 0, 1);
    seg("p_mg",   0, 0, LT_GRN, LT_RED, 0, 3);
    seg("p_my",   0, 0, LT_YEL, LT_RED, 0, 2);
    seg("p_ara",  0, 1, LT_RED, LT_RED, 0, 1);
    seg("p_wk0",  0, 0, LT_RED, LT_RED, 1, 1);
    seg("p_wkp",  0, 1, LT_RED, LT_RED, 1, 1);
    seg("p_wk2",  0, 0, LT_RED, LT_RED, 1, 1);
    seg("p_hold", 0, 0, LT_GRN, LT_RED, 0, 12);

    // Ped request in SIDE_GREEN: WALK after ALL_RED_B
    do_reset();
    seg("ps_arb",  0, 0, LT_RED, LT_RED, 0, 1);
    seg("ps_mg",   1, 0, LT_GRN, LT_RED, 0, 4);
    seg("ps_my",   1, 0, LT_YEL, LT_RED, 0, 2);
    seg("ps_ara",  1, 0, LT_RED, LT_RED, 0, 1);
    seg("ps_sgp",  1, 1, LT_RED, LT_GRN, 0, 1);
    seg("ps_sg",   0, 0, LT_RED, LT_GRN, 0, 3);
    seg("ps_sy",   0, 0, LT_RED, LT_YEL, 0, 2);
    seg("ps_arb2", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("ps_wk",   0, 0, LT_RED, LT_RED, 1, 3);
    seg("ps_mg2",  0, 0, LT_GRN, LT_RED, 0, 2);

    // Reset mid-SIDE_GREEN aborts with no yellow
    do_reset();
    seg("r_arb", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("r_mg",  1, 0, LT_GRN, LT_RED, 0, 4);
    seg("r_my",  1, 0, LT_YEL, LT_RED, 0, 2);
    seg("r_ara", 1, 0, LT_RED, LT_RED, 0, 1);
    seg("r_sg",  1, 0, LT_RED, LT_GRN, 0, 2);
    do_reset();
    seg("r_arb2", 0, 0, LT_RED, LT_RED, 0, 1);
    seg("r_mg2",  0, 0, LT_GRN, LT_RED, 0, 3);

    // Random traffic against the model
    rs = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (i % 23 == 0) rs = 1'($urandom_range(0, 1));
      if (i == 300) do_reset();
      step(rs, ($urandom_range(0, 11) == 0));
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
